uart_rx_fsm: RTL and testbench



---
 rtl/uart_rx_fsm.sv | 81 ++++++++
 tb/tb_uart_rx_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 UART receiver sampling RxD on OVERSAMPLE rx_en ticks per bit.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_error,
  output logic       rx_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam logic [3:0] HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL = 4'(OVERSAMPLE - 1);
  state_t     r_state;
  logic [1:0] r_sync;
  logic [3:0] r_tcnt;
  logic [2:0] r_bcnt;
  logic [7:0] r_sh;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ferr;
  logic       w_rxs;
  assign w_rxs          = r_sync[1];
  assign rx_data        = r_data;
  assign rx_valid       = r_valid;
  assign rx_frame_error = r_ferr;
  assign rx_busy        = r_state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], RxD};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: if (!w_rxs) begin
          r_state <= START;
          r_tcnt  <= '0;
        end
        START: if (rx_en) begin
          if (r_tcnt == HALF) begin
            r_state <= w_rxs ? IDLE : DATA;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
          end else r_tcnt <= r_tcnt + 4'd1;
        end
        DATA: if (rx_en) begin
          if (r_tcnt == FULL) begin
            r_sh    <= {w_rxs, r_sh[7:1]};
            r_tcnt  <= '0;
            r_bcnt  <= r_bcnt + 3'd1;
            r_state <= r_bcnt == 3'd7 ? STOP : DATA;
          end else r_tcnt <= r_tcnt + 4'd1;
        end
        // Leaving at mid-stop leaves half a bit to catch an immediately following start edge.
        STOP: if (rx_en) begin
          if (r_tcnt == FULL) begin
            r_tcnt  <= '0;
            r_state <= w_rxs ? IDLE : BREAK;
            r_valid <= w_rxs;
            r_ferr  <= !w_rxs;
            if (w_rxs) r_data <= r_sh;
          end else r_tcnt <= r_tcnt + 4'd1;
        end
        BREAK: if (w_rxs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: self-checking bench for uart_rx_fsm at OVERSAMPLE 16 and 8.
module tb_uart_rx_fsm;
  localparam int DIV  = 4;
  localparam int BT16 = 16 * DIV * 10;
  localparam int BT8  = 8 * DIV * 10;
  localparam int BT8F = 314;
  typedef struct packed {logic err; logic [7:0] d;} ev_t;
  typedef struct {logic [7:0] b; logic stop; int gap; logic exp_err; logic [7:0] exp_data;} vec_t;
  logic       clk = 1'b0, reset_n = 1'b0, rx_en = 1'b0, rxd16 = 1'b1, rxd8 = 1'b1;
  logic [7:0] data16, data8, prev16, prev8;
  logic       valid16, valid8, ferr16, ferr8, busy16, busy8;
  ev_t        got16[$], got8[$], exp16[$], exp8[$];
  logic [7:0] model16 = 8'h00, model8 = 8'h00;
  int         checks = 0, errors = 0;

  uart_rx_fsm #(.OVERSAMPLE(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .RxD(rxd16),
    .rx_data(data16), .rx_valid(valid16), .rx_frame_error(ferr16), .rx_busy(busy16));
  uart_rx_fsm #(.OVERSAMPLE(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .RxD(rxd8),
    .rx_data(data8), .rx_valid(valid8), .rx_frame_error(ferr8), .rx_busy(busy8));

  initial forever #5 clk = ~clk;
  initial begin : g_tick
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      rx_en = (c % DIV) == 0;
      c++;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, req);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic f, input logic [7:0] d, input logic [7:0] p);
    if (v || f) begin
      if (w == 16) got16.push_back(ev_t'{f, d});
      else got8.push_back(ev_t'{f, d});
      chk($sformatf("strobe_excl%0d", w), 32'(v & f), 0);
    end
    if (reset_n && d !== p) chk($sformatf("data_update_with_valid%0d", w), 32'(v), 1);
  endtask

  always @(negedge clk) begin
    mon(16, valid16, ferr16, data16, prev16);
    mon(8, valid8, ferr8, data8, prev8);
    prev16 <= data16;
    prev8  <= data8;
  end

  task automatic send(input int w, input logic [7:0] b, input logic stop, input int gap, input int bt);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10 + gap; i++) begin
      if (w == 16) rxd16 = (i < 10) ? f[i] : 1'b1;
      else rxd8 = (i < 10) ? f[i] : 1'b1;
      #(bt);
    end
  endtask

  // Frame-level reference: a good stop delivers the byte, a bad stop reports the last good byte.
  task automatic model_frame(input int w, input logic [7:0] b, input logic stop);
    if (w == 16) begin
      exp16.push_back(stop ? ev_t'{1'b0, b} : ev_t'{1'b1, model16});
      if (stop) model16 = b;
    end else begin
      exp8.push_back(stop ? ev_t'{1'b0, b} : ev_t'{1'b1, model8});
      if (stop) model8 = b;
    end
  endtask

  task automatic compare(input string tag, input int w);
    ev_t        g[$], e[$];
    logic [7:0] d, m;
    logic       bsy;
    if (w == 16) begin
      g = got16; e = exp16; d = data16; m = model16; bsy = busy16;
      got16.delete(); exp16.delete();
    end else begin
      g = got8; e = exp8; d = data8; m = model8; bsy = busy8;
      got8.delete(); exp8.delete();
    end
    chk({tag, " strobe count"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++)
      chk($sformatf("%s event%0d {err,data}", tag, i), 32'(g[i]), 32'(e[i]));
    chk({tag, " rx_data"}, 32'(d), 32'(m));
    chk({tag, " rx_busy idle"}, 32'(bsy), 0);
  endtask

  initial begin
    vec_t tbl[10];
    logic [7:0] rb;
    logic       rs;
    tbl[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 1, 1'b0, 8'hFF};
    tbl[3] = '{8'h3C, 1'b0, 1, 1'b1, 8'hFF};
    tbl[4] = '{8'h55, 1'b1, 0, 1'b0, 8'h55};
    tbl[5] = '{8'h01, 1'b1, 1, 1'b0, 8'h01};
    tbl[6] = '{8'h80, 1'b1, 0, 1'b0, 8'h80};
    tbl[7] = '{8'hC3, 1'b0, 2, 1'b1, 8'h80};
    tbl[8] = '{8'h7E, 1'b1, 1, 1'b0, 8'h7E};
    tbl[9] = '{8'hE7, 1'b1, 1, 1'b0, 8'hE7};
    repeat (4) @(negedge clk);
    chk("reset rx_data16", 32'(data16), 0);
    chk("reset rx_valid16", 32'(valid16), 0);
    chk("reset rx_frame_error16", 32'(ferr16), 0);
    chk("reset rx_busy16", 32'(busy16), 0);
    chk("reset rx_data8", 32'(data8), 0);
    chk("reset rx_busy8", 32'(busy8), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    foreach (tbl[i]) begin
      send(16, tbl[i].b, tbl[i].stop, tbl[i].gap, BT16);
      exp16.push_back(ev_t'{tbl[i].exp_err, tbl[i].exp_data});
      model16 = tbl[i].exp_data;
      compare($sformatf("vec%0d", i), 16);
    end
    fork
      send(16, 8'hA5, 1'b1, 1, BT16);
      begin
        #20 chk("busy before sync latency", 32'(busy16), 0);
        #10 chk("busy after start edge", 32'(busy16), 1);
        #(BT16 * 4) chk("busy mid-frame", 32'(busy16), 1);
      end
    join
    model_frame(16, 8'hA5, 1'b1);
    compare("good A5", 16);
    rxd16 = 1'b0;
    #160 rxd16 = 1'b1;
    chk("glitch busy in start", 32'(busy16), 1);
    #(BT16);
    compare("glitch", 16);
    send(16, 8'h3C, 1'b0, 0, BT16);
    model_frame(16, 8'h3C, 1'b0);
    #(BT16 * 3);
    chk("break busy while low", 32'(busy16), 1);
    rxd16 = 1'b1;
    #(BT16);
    compare("framing error + break", 16);
    send(16, 8'h55, 1'b1, 1, BT16);
    model_frame(16, 8'h55, 1'b1);
    compare("after break 55", 16);
    fork
      send(16, 8'h81, 1'b1, 2, BT16);
      begin
        #(BT16 * 11 / 2 + 2) reset_n = 1'b0;
        #1;
        chk("midframe reset rx_data", 32'(data16), 0);
        chk("midframe reset rx_valid", 32'(valid16), 0);
        chk("midframe reset rx_frame_error", 32'(ferr16), 0);
        chk("midframe reset rx_busy", 32'(busy16), 0);
        #(BT16 * 3) reset_n = 1'b1;
      end
    join
    model16 = 8'h00;
    model8  = 8'h00;
    compare("reset abort", 16);
    send(16, 8'h81, 1'b1, 1, BT16);
    model_frame(16, 8'h81, 1'b1);
    compare("after reset 81", 16);
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      rs = $urandom_range(0, 4) != 0;
      send(16, rb, rs, rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)), BT16);
      model_frame(16, rb, rs);
    end
    #(BT16);
    compare("random", 16);
    send(8, 8'h5A, 1'b1, 1, BT8);
    model_frame(8, 8'h5A, 1'b1);
    send(8, 8'hA5, 1'b1, 1, BT8F);
    model_frame(8, 8'hA5, 1'b1);
    #(BT8);
    compare("os8 fast baud", 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
